reg_writeback: RTL

REG_WRITEBACK -- requirements
Module: reg_writeback

---
 rtl/reg_writeback.sv | 130 +++++++++++++
 1 files changed

// File: rtl/reg_writeback.sv
// Register-file writeback arbiter: merges ALU results with buffered load results,
// tracks outstanding loads for hazard queries and forces the load buffer through on starvation.
module reg_writeback #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [4:0]  alu_addr,
  input  logic [31:0] alu_data,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [4:0]  mem_addr,
  input  logic [31:0] mem_data,
  input  logic        iss_valid,
  input  logic [4:0]  iss_addr,
  input  logic [4:0]  q_addr1,
  input  logic [4:0]  q_addr2,
  output logic        q_busy1,
  output logic        q_busy2,
  output logic        wr,
  output logic [4:0]  addr3,
  output logic [31:0] data3,
  output logic        alu_stall,
  output logic [4:0]  fifo_count
);
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = 5;
  localparam int unsigned STV_W = $clog2(STARVE_MAX + 1);

  logic [4:0]       buf_addr_q [FIFO_DEPTH];
  logic [31:0]      buf_data_q [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [STV_W-1:0] starve_q, starve_d;
  logic             stall_q, stall_d;
  logic [31:0]      pend_q, pend_d;
  logic             wr_q, wr_d;
  logic             wr_mem_q, wr_mem_d;
  logic [4:0]       addr3_q, addr3_d;
  logic [31:0]      data3_q, data3_d;
  logic             empty_c, alu_req_c, deq_c, enq_c;

  // Buffer head wins during a forced stall; ALU requests during a stall are dropped.
  assign mem_ready = !reset && (count_q < CNT_W'(FIFO_DEPTH));
  assign empty_c   = (count_q == '0);
  assign alu_req_c = alu_valid && (alu_addr != 5'd0) && !stall_q;
  assign deq_c     = !empty_c && (stall_q || !alu_req_c);
  assign enq_c     = mem_valid && mem_ready && (mem_addr != 5'd0);

  assign q_busy1    = (q_addr1 != 5'd0) && pend_q[q_addr1];
  assign q_busy2    = (q_addr2 != 5'd0) && pend_q[q_addr2];
  assign wr         = wr_q;
  assign addr3      = addr3_q;
  assign data3      = data3_q;
  assign alu_stall  = stall_q;
  assign fifo_count = count_q;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    starve_d = starve_q;
    stall_d  = 1'b0;
    pend_d   = pend_q;
    wr_d     = 1'b0;
    wr_mem_d = 1'b0;
    addr3_d  = '0;
    data3_d  = '0;

    if (deq_c) begin
      wr_d     = 1'b1;
      wr_mem_d = 1'b1;
      addr3_d  = buf_addr_q[rd_ptr_q];
      data3_d  = buf_data_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else if (alu_req_c) begin
      wr_d    = 1'b1;
      addr3_d = alu_addr;
      data3_d = alu_data;
    end

    if (enq_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(enq_c) - CNT_W'(deq_c);

    if (empty_c || deq_c) starve_d = '0;
    else if (alu_req_c)   starve_d = starve_q + STV_W'(1);
    stall_d = !empty_c && alu_req_c && (starve_q == STV_W'(STARVE_MAX - 1));

    // A load stays busy until its write is on the register-file port; a new issue wins.
    if (wr_q && wr_mem_q) pend_d[addr3_q] = 1'b0;
    if (iss_valid && (iss_addr != 5'd0)) pend_d[iss_addr] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (enq_c) begin
      buf_addr_q[wr_ptr_q] <= mem_addr;
      buf_data_q[wr_ptr_q] <= mem_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
      stall_q  <= 1'b0;
      pend_q   <= '0;
      wr_q     <= 1'b0;
      wr_mem_q <= 1'b0;
      addr3_q  <= '0;
      data3_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      stall_q  <= stall_d;
      pend_q   <= pend_d;
      wr_q     <= wr_d;
      wr_mem_q <= wr_mem_d;
      addr3_q  <= addr3_d;
      data3_q  <= data3_d;
    end
  end
endmodule
